fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the asynchronous FIFO (winc/wdata/wfull, wclk domain) among NREQ independent 16-bit word producers. Each producer uses a valid/ack handshake. The arbiter grants one producer at a time for a bounded burst, stalls cleanly on wfull, and keeps a running count of words written. It sits between the producers and the FIFO write side, and is the only driver of winc/wdata.

## Interface
- NREQ, 4: number of requesters, 2..8
- DW, 16: data width, equal to FIFO word width
- BURST, 4: maximum words transferred per grant, 1..15
- wclk  in  1: write-domain clock
- wrst_n  in  1: reset, asynchronous, active-low
- req  in  NREQ: req[i]=1 means producer i presents a valid word on data slice i
- data  in  NREQ*DW: producer words, slice i = data[i*DW +: DW]
- ack  out  NREQ: ack[i]=1 means the word on slice i is written at this rising edge
- winc  out  1: FIFO write enable
- wdata  out  DW: FIFO write data
- wfull  in  1: FIFO full, synchronous to wclk
- grant_id  out  $clog2(NREQ): index of the current grantee, valid while busy=1
- busy  out  1: a grant is held
- wr_count  out  16: total words written since reset, wraps 0xFFFF->0x0000

## Operation
- State machine has three states: IDLE, ARB, GRANT.
- IDLE: no grant held.
  - If any req bit is set, go to ARB; otherwise stay in IDLE.
- ARB: select the first requester with req=1, searching upward from last_grant+1 and wrapping modulo NREQ.
  - Register the winner into grant_id and last_grant, clear burst_cnt, go to GRANT.
  - If req has dropped to all-zero by this cycle, return to IDLE and leave last_grant unchanged.
- GRANT: with g = grant_id, a transfer happens when req[g]=1 and wfull=0.
  - winc, ack[g] and wdata=data[g] are combinational, all in the same cycle.
  - Each transfer increments burst_cnt and wr_count.
- Release from GRANT to IDLE happens when either:
  - the transfer that makes burst_cnt equal BURST completes, or
  - req[g]=0 in a cycle where wfull=0.
- wfull=1 while in GRANT: no transfer happens, the grant is held, burst_cnt is frozen, and the state does not change. An idle grantee during wfull is not released.
- Outside GRANT: winc=0, ack=0, wdata=0.
- ack is one-hot or zero. ack[i] is never asserted for i != grant_id.
- Producers advance their data at the edge where their ack is high.
- Reset: all of the following clear asynchronously, and winc/ack drop immediately:
  - state=IDLE, last_grant=NREQ-1 (so requester 0 wins first), grant_id=0, burst_cnt=0, wr_count=0, busy=0.

## Timing
- req rise in IDLE to first possible winc: 2 cycles (IDLE->ARB edge, ARB->GRANT edge, then transfer in the GRANT cycle).
- Inside a grant, throughput is one word per cycle while req[g]=1 and wfull=0.
- Grant turnaround costs 2 idle cycles (GRANT->IDLE->ARB) before the next GRANT.
- wfull is sampled combinationally in the same cycle. winc is never high while wfull=1.
- busy=1 exactly in ARB and GRANT.
- wr_count and burst_cnt update at the edge of the transfer cycle.
- Simultaneous final-burst transfer and wfull rise: the transfer did not occur (wfull=1 blocks it), so the grant is held.

## Structure
- Package fifo_wr_pkg holds:
  - state enum {IDLE, ARB, GRANT},
  - default DW,
  - a clog2 helper constant for the grant index width.
- Sub-module rr_pick: purely combinational rotating priority selector.
  - Inputs: req and last_grant. Outputs: winner index and any-valid.
  - Instantiated once and used in ARB.
- Top-level holds the FSM, burst/word counters, and the output muxing.

## Test plan
- Single requester: req[2] held high with data 0x0001, 0x0002, ... -> first winc 2 cycles after req, 4 consecutive writes 0x0001–0x0004, release, 2-cycle gap, next burst resumes at 0x0005.
- All four requesting continuously, first grant after reset -> grant order 0,1,2,3,0,... with 4 words each; wr_count=16 after one round plus bubbles.
- wfull asserted for 5 cycles mid-burst on requester 1 after its 2nd word -> no winc/ack during the stall, grant_id stays 1, exactly 2 more words are written after wfull falls.
- Requester drops req after 1 word -> immediate release; next requester in rotation granted 2 cycles later; burst_cnt does not carry over.
- Drive 65537 transfers -> wr_count wraps to 0x0001.
- Assert wrst_n low in GRANT mid-transfer -> winc/ack/busy are 0 in the same cycle; after release, requester 0 wins first even if requester 3 was the previous grantee.

Source files
------------

// File: rtl/fifo_wr_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_wr_pkg;

  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

  localparam int unsigned DEF_DW   = 16;
  localparam int unsigned DEF_NREQ = 4;

  // Grant index width; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_GW = idx_w(DEF_NREQ);

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority selector: first set req bit above last_grant, wrapping.
module rr_pick
  import fifo_wr_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned GW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last_grant,
  output logic [GW-1:0]   winner,
  output logic            valid
);

  int unsigned idx;
  logic [GW-1:0] sel;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      sel = GW'(idx);
      if (!valid && req[sel]) begin
        winner = sel;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ producers.
module fifo_write_arbiter
  import fifo_wr_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned BURST = 4,
  localparam int unsigned GW   = idx_w(NREQ)
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data,
  output logic [NREQ-1:0]    ack,
  output logic               winc,
  output logic [DW-1:0]      wdata,
  input  logic               wfull,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic [15:0]        wr_count
);

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [3:0]    burst_cnt;
  logic [GW-1:0] pick;
  logic          pick_valid;
  logic          xfer;

  rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
    .req       (req),
    .last_grant(last_grant),
    .winner    (pick),
    .valid     (pick_valid)
  );

  // Transfer is combinational on wfull so winc can never coincide with full.
  assign xfer = (state == GRANT) && req[grant_id] && !wfull;
  assign winc = xfer;
  assign busy = (state != IDLE);

  always_comb begin
    ack   = '0;
    wdata = '0;
    if (state == GRANT) begin
      wdata         = data[DW*int'(grant_id) +: DW];
      ack[grant_id] = xfer;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state      <= IDLE;
      last_grant <= GW'(NREQ - 1);
      grant_id   <= '0;
      burst_cnt  <= '0;
      wr_count   <= '0;
    end else begin
      unique case (state)
        IDLE: if (|req) state <= ARB;
        ARB: begin
          if (pick_valid) begin
            grant_id   <= pick;
            last_grant <= pick;
            burst_cnt  <= '0;
            state      <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (xfer) begin
            burst_cnt <= burst_cnt + 4'd1;
            wr_count  <= wr_count + 16'd1;
            if (burst_cnt == 4'(BURST - 1)) state <= IDLE;
          end else if (!wfull) begin
            // No transfer without full means the grantee withdrew.
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: expected writes queued, popped on winc.
module tb_fifo_write_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req;
  logic [63:0] data;
  logic [3:0]  ack;
  logic        winc;
  logic [15:0] wdata;
  logic        wfull;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] wr_count;

  logic [1:0]  req2;
  logic [31:0] data2;
  logic [1:0]  ack2;
  logic        winc2;
  logic [15:0] wdata2;
  logic        wfull2;
  logic [0:0]  gid2;
  logic        busy2;
  logic [15:0] wrc2;

  logic [15:0] pval [4];

  typedef struct {
    logic [1:0]  id;
    logic [15:0] word;
  } exp_t;
  exp_t exp_q[$];

  int          total = 0;
  int          bad   = 0;
  int          exp_wr;
  logic [31:0] hist;
  logic [1:0]  s_gid;
  logic        s_busy;

  always #5 wclk = ~wclk;

  always_comb begin
    for (int i = 0; i < 4; i++) data[i*16 +: 16] = pval[i];
  end

  fifo_write_arbiter #(.NREQ(4), .DW(16), .BURST(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .data(data), .ack(ack),
    .winc(winc), .wdata(wdata), .wfull(wfull), .grant_id(grant_id),
    .busy(busy), .wr_count(wr_count)
  );

  fifo_write_arbiter #(.NREQ(2), .DW(16), .BURST(15)) dut_wrap (
    .wclk(wclk), .wrst_n(wrst_n), .req(req2), .data(data2), .ack(ack2),
    .winc(winc2), .wdata(wdata2), .wfull(wfull2), .grant_id(gid2),
    .busy(busy2), .wr_count(wrc2)
  );

  task automatic push(input int id, input logic [15:0] w);
    exp_t e;
    e.id   = 2'(id);
    e.word = w;
    exp_q.push_back(e);
  endtask

  task automatic step();
    logic [3:0] a;
    exp_t e;
    @(negedge wclk);
    a      = ack;
    s_gid  = grant_id;
    s_busy = busy;
    hist   = {hist[30:0], winc};
    total++;
    if (winc && wfull) begin
      bad++;
      $display("FAIL winc_during_full: winc=%b wfull=%b required winc=0", winc, wfull);
    end
    if (winc) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: id=%0d wdata=%h required no write", grant_id, wdata);
      end else begin
        e = exp_q.pop_front();
        exp_wr++;
        if (grant_id !== e.id || wdata !== e.word || ack !== (4'b0001 << e.id)) begin
          bad++;
          $display("FAIL write: id=%0d wdata=%h ack=%b required id=%0d wdata=%h ack=%b",
                   grant_id, wdata, ack, e.id, e.word, 4'b0001 << e.id);
        end
      end
    end else begin
      total++;
      if (ack !== 4'b0000) begin
        bad++;
        $display("FAIL ack_idle: ack=%b required 0000", ack);
      end
    end
    @(posedge wclk);
    #1;
    for (int i = 0; i < 4; i++) if (a[i]) pval[i] = pval[i] + 16'd1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    req    = '0;
    wfull  = 1'b0;
    req2   = '0;
    exp_q.delete();
    hist   = '0;
    exp_wr = 0;
    repeat (2) @(posedge wclk);
    #1 wrst_n = 1'b1;
  endtask

  task automatic end_check(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending: left=%0d required 0", name, exp_q.size());
    end
    total++;
    if (wr_count !== 16'(exp_wr)) begin
      bad++;
      $display("FAIL %s_wr_count: got=%h required %h", name, wr_count, 16'(exp_wr));
    end
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    req = '0; wfull = 1'b0; req2 = '0;
    for (int i = 0; i < 4; i++) pval[i] = '0;
    data2 = '0; wfull2 = 1'b0;
    #2;
    total++;
    if ({winc, ack, busy, grant_id, wr_count} !== 24'h0) begin
      bad++;
      $display("FAIL reset_state: winc=%b ack=%b busy=%b gid=%0d wr_count=%h required all 0",
               winc, ack, busy, grant_id, wr_count);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    pval[2] = 16'h0001;
    for (int w = 1; w <= 10; w++) push(2, 16'(w));
    req = 4'b0100;
    for (int s = 0; s < 16; s++) step();
    req = '0;
    repeat (2) step();
    total++;
    if (hist[17:0] !== 18'b001111001111001100) begin
      bad++;
      $display("FAIL single_timing: winc_hist=%b required %b", hist[17:0], 18'b001111001111001100);
    end
    end_check("single");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) pval[i] = 16'(i << 12) | 16'h0001;
    for (int i = 0; i < 4; i++)
      for (int w = 1; w <= 4; w++) push(i, 16'(i << 12) | 16'(w));
    req = 4'b1111;
    for (int s = 0; s < 24; s++) step();
    req = '0;
    repeat (2) step();
    total++;
    if (hist[25:0] !== 26'b00111100111100111100111100) begin
      bad++;
      $display("FAIL rr_timing: winc_hist=%b required %b", hist[25:0], 26'b00111100111100111100111100);
    end
    total++;
    if (wr_count !== 16'd16) begin
      bad++;
      $display("FAIL rr_count: got=%0d required 16", wr_count);
    end
    end_check("rr");
  endtask

  task automatic test_wfull_stall();
    do_reset();
    pval[1] = 16'h1001;
    for (int w = 1; w <= 4; w++) push(1, 16'h1000 | 16'(w));
    req = 4'b0010;
    repeat (4) step();
    wfull = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      total++;
      if (s_gid !== 2'd1 || s_busy !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold: gid=%0d busy=%b required gid=1 busy=1", s_gid, s_busy);
      end
    end
    wfull = 1'b0;
    repeat (2) step();
    req = '0;
    step();
    total++;
    if (hist[11:0] !== 12'b001100000110) begin
      bad++;
      $display("FAIL stall_timing: winc_hist=%b required %b", hist[11:0], 12'b001100000110);
    end
    end_check("stall");
  endtask

  task automatic test_early_release();
    do_reset();
    pval[0] = 16'h0001;
    pval[1] = 16'h1001;
    push(0, 16'h0001);
    for (int w = 1; w <= 4; w++) push(1, 16'h1000 | 16'(w));
    req = 4'b0011;
    repeat (3) step();
    req = 4'b0010;
    repeat (3) step();
    step();
    total++;
    if (s_gid !== 2'd1) begin
      bad++;
      $display("FAIL release_next: gid=%0d required 1", s_gid);
    end
    repeat (3) step();
    req = '0;
    step();
    total++;
    if (hist[10:0] !== 11'b00100011110) begin
      bad++;
      $display("FAIL release_timing: winc_hist=%b required %b", hist[10:0], 11'b00100011110);
    end
    end_check("release");
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    pval[2] = 16'h2001;
    push(2, 16'h2001);
    req = 4'b0100;
    repeat (3) step();
    @(negedge wclk);
    total++;
    if (winc !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: winc=%b required 1", winc);
    end
    #1 wrst_n = 1'b0;
    #1;
    total++;
    if ({winc, ack, busy, wr_count} !== 22'h0) begin
      bad++;
      $display("FAIL midrst_drop: winc=%b ack=%b busy=%b wr_count=%h required all 0",
               winc, ack, busy, wr_count);
    end
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    exp_q.delete();
    exp_wr = 0;
    hist = '0;
    pval[0] = 16'h0001;
    push(0, 16'h0001);
    req = 4'b1101;
    repeat (3) step();
    total++;
    if (s_gid !== 2'd0 || hist[2:0] !== 3'b001) begin
      bad++;
      $display("FAIL midrst_first: gid=%0d hist=%b required gid=0 hist=001", s_gid, hist[2:0]);
    end
    req = '0;
    repeat (2) step();
    end_check("midrst");
  endtask

  task automatic test_wrap();
    int n;
    int cyc;
    logic w;
    do_reset();
    req2 = 2'b01;
    n = 0;
    cyc = 0;
    while (n < 65537 && cyc < 80000) begin
      @(negedge wclk);
      cyc++;
      w = winc2;
      if (w) n++;
      @(posedge wclk);
      #1;
      if (w && n >= 65535) begin
        total++;
        if (wrc2 !== 16'(n)) begin
          bad++;
          $display("FAIL wrap_count: writes=%0d got=%h required %h", n, wrc2, 16'(n));
        end
      end
    end
    req2 = '0;
    total++;
    if (n != 65537) begin
      bad++;
      $display("FAIL wrap_timeout: writes=%0d required 65537", n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wfull_stall();
    test_early_release();
    test_reset_mid_grant();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
